// File: rtl/vid_stream_source_if.sv
// AXI4-Stream video beat bundle: 32-bit pixel word with
// line (tlast) and frame (tuser) markers.
interface vid_stream_source_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/vid_stream_source.sv
// Framebuffer-to-AXI4-Stream video source: walks a 2D window
// through a 1-cycle read port into a small tagged output FIFO.
module vid_stream_source #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              m_axis_vid_aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [15:0]       cfg_stride,
  input  logic [11:0]       cfg_hwords,
  input  logic [11:0]       cfg_vlines,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  vid_stream_source_if.master m_axis_vid,
  output logic              busy,
  output logic              frame_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  state_e            state_q;
  logic [11:0]       hw_q;
  logic [11:0]       vl_q;
  logic [11:0]       x_q;
  logic [11:0]       y_q;
  logic [15:0]       stride_q;
  logic [ADDR_W-1:0] line_q;
  logic [ADDR_W-1:0] addr_q;
  logic              frame_done_q;

  logic              inf_q;
  logic              inf_user_q;
  logic              inf_last_q;
  logic [33:0]       fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q;
  logic [PW-1:0]     rp_q;
  logic [CW-1:0]     cnt_q;

  logic              cfg_ok;
  logic              x_end;
  logic              y_end;
  logic              push;
  logic              pop;
  logic              valid;
  logic              drain_end;
  logic              relatch;
  logic [CW:0]       outst;
  logic [33:0]       head;
  logic [ADDR_W-1:0] line_d;

  assign cfg_ok = enable && (cfg_hwords != '0)
                  && (cfg_vlines != '0);
  assign x_end  = x_q == hw_q - 12'd1;
  assign y_end  = y_q == vl_q - 12'd1;
  assign outst  = {1'b0, cnt_q} + (CW+1)'(inf_q);
  assign mem_rd = (state_q == FETCH)
                  && (outst < (CW+1)'(FIFO_DEPTH));
  assign mem_addr = addr_q;
  assign line_d   = line_q + ADDR_W'(stride_q);

  assign valid = cnt_q != '0;
  assign push  = inf_q;
  assign pop   = valid && m_axis_vid.tready;
  assign head  = fifo_q[rp_q];

  // Leave DRAIN on the edge the final beat handshakes, so a
  // back-to-back frame starts reading without an empty cycle.
  assign drain_end = (state_q == DRAIN) && !inf_q
                     && ((cnt_q == '0)
                     || ((cnt_q == CW'(1)) && pop));
  assign relatch = cfg_ok
                   && ((state_q == IDLE) || drain_end);

  assign busy       = state_q != IDLE;
  assign frame_done = frame_done_q;

  assign m_axis_vid.tvalid = valid;
  assign m_axis_vid.tdata  = valid ? head[31:0] : '0;
  assign m_axis_vid.tlast  = valid && head[32];
  assign m_axis_vid.tuser  = valid && head[33];

  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      hw_q         <= '0;
      vl_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      stride_q     <= '0;
      line_q       <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= drain_end && pop;
      if (relatch) begin
        state_q  <= FETCH;
        hw_q     <= cfg_hwords;
        vl_q     <= cfg_vlines;
        stride_q <= cfg_stride;
        line_q   <= cfg_base;
        addr_q   <= cfg_base;
        x_q      <= '0;
        y_q      <= '0;
      end else begin
        unique case (state_q)
          FETCH: begin
            if (mem_rd) begin
              if (x_end) begin
                x_q    <= '0;
                y_q    <= y_q + 12'd1;
                line_q <= line_d;
                addr_q <= line_d;
                if (y_end) state_q <= DRAIN;
              end else begin
                x_q    <= x_q + 12'd1;
                addr_q <= addr_q + ADDR_W'(4);
              end
            end
          end
          DRAIN: begin
            if (drain_end) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Tags ride one cycle behind the strobe to meet mem_rdata.
  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      inf_q      <= 1'b0;
      inf_user_q <= 1'b0;
      inf_last_q <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
    end else begin
      inf_q      <= mem_rd;
      inf_user_q <= (x_q == '0) && (y_q == '0);
      inf_last_q <= x_end;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge m_axis_vid_aclk) begin
    if (push) begin
      fifo_q[wp_q] <= {inf_user_q, inf_last_q, mem_rdata};
    end
  end

endmodule

// File: tb/tb_vid_stream_source.sv
// Bench for vid_stream_source: frame-level reference model
// plus a per-cycle stream/read monitor.
module tb_vid_stream_source;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
    logic        fin;
  } beat_t;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [31:0] cfg_base;
  logic [15:0] cfg_stride;
  logic [11:0] cfg_hwords;
  logic [11:0] cfg_vlines;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic        frame_done;

  vid_stream_source_if vif();

  int          tests = 0;
  int          fails = 0;
  int          ready_pct = 100;
  bit          mon_en = 1'b0;
  beat_t       exp_q[$];
  logic [31:0] addr_q[$];
  beat_t       me;
  int          issued = 0;
  int          pops = 0;
  int          fd_cnt = 0;
  bit          fd_pend = 1'b0;
  bit          prev_v = 1'b0;
  bit          prev_r = 1'b0;
  logic [33:0] prev_pl = '0;

  always #5 clk = ~clk;

  vid_stream_source #(
    .FIFO_DEPTH(DEPTH),
    .ADDR_W(32)
  ) dut (
    .m_axis_vid_aclk(clk),
    .aresetn(aresetn),
    .enable(enable),
    .cfg_base(cfg_base),
    .cfg_stride(cfg_stride),
    .cfg_hwords(cfg_hwords),
    .cfg_vlines(cfg_vlines),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .m_axis_vid(vif),
    .busy(busy),
    .frame_done(frame_done)
  );

  function automatic logic [31:0] pix(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Synchronous-read framebuffer; garbage when not read.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= pix(mem_addr);
    else        mem_rdata <= $urandom;
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic add_frame(input logic [31:0] b,
                           input logic [15:0] s,
                           input int hw, input int vl);
    for (int y = 0; y < vl; y++) begin
      for (int x = 0; x < hw; x++) begin
        logic [31:0] a;
        beat_t e;
        a = b + 32'(y) * 32'(s) + 32'(4 * x);
        addr_q.push_back(a);
        e.data = pix(a);
        e.last = (x == hw - 1);
        e.user = (x == 0) && (y == 0);
        e.fin  = (x == hw - 1) && (y == vl - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] b,
                         input logic [15:0] s,
                         input int hw, input int vl);
    cfg_base   = b;
    cfg_stride = s;
    cfg_hwords = 12'(hw);
    cfg_vlines = 12'(vl);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      tick();
      n++;
    end
    chk({name, "_in_time"}, 64'(n < bound), 64'd1);
    if (n >= bound) begin
      exp_q.delete();
      addr_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_rd"}, 64'(mem_rd), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_tvalid"}, 64'(vif.tvalid), 64'd0);
    chk({tag, "_tdata"}, 64'(vif.tdata), 64'd0);
    chk({tag, "_tlast"}, 64'(vif.tlast), 64'd0);
    chk({tag, "_tuser"}, 64'(vif.tuser), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
  endtask

  task automatic flush_model();
    exp_q.delete();
    addr_q.delete();
    issued  = 0;
    pops    = 0;
    fd_pend = 1'b0;
    prev_v  = 1'b0;
    prev_r  = 1'b0;
  endtask

  initial begin
    vif.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      vif.tready = (int'($urandom_range(99)) < ready_pct);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (fd_pend || frame_done)
          chk("frame_done", 64'(frame_done), 64'(fd_pend));
        if (frame_done) fd_cnt++;
        fd_pend = 1'b0;
        if (prev_v && !prev_r) begin
          chk("tvalid_hold", 64'(vif.tvalid), 64'd1);
          chk("payload_hold",
              64'({vif.tuser, vif.tlast, vif.tdata}),
              64'(prev_pl));
        end
        if (mem_rd) begin
          issued++;
          chk("outstanding", 64'((issued - pops) <= DEPTH),
              64'd1);
          if (addr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_read: got addr %0h, expected no read",
                     mem_addr);
          end else begin
            chk("mem_addr", 64'(mem_addr),
                64'(addr_q.pop_front()));
          end
        end
        if (vif.tvalid && vif.tready) begin
          pops++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got %0h, expected no beat",
                     vif.tdata);
          end else begin
            me = exp_q.pop_front();
            chk("beat",
                64'({vif.tuser, vif.tlast, vif.tdata}),
                64'({me.user, me.last, me.data}));
            fd_pend = me.fin;
          end
        end
        prev_v  = vif.tvalid;
        prev_r  = vif.tready;
        prev_pl = {vif.tuser, vif.tlast, vif.tdata};
      end
    end
  end

  initial begin
    int p0;
    int f0;
    int i0;
    int n;
    bit seen;
    bit max_busy;
    bit max_v;

    aresetn = 1'b0;
    enable  = 1'b0;
    set_cfg(32'h0, 16'h0, 0, 0);
    repeat (3) tick();
    chk_zero("reset");
    aresetn = 1'b1;
    tick();
    mon_en = 1'b1;

    // Basic 4x2 frame and first-beat latency.
    ready_pct = 100;
    set_cfg(32'h1000, 16'h20, 4, 2);
    add_frame(32'h1000, 16'h20, 4, 2);
    chk("model_addr4", 64'(addr_q[4]), 64'h1020);
    chk("model_addr7", 64'(addr_q[7]), 64'h102C);
    p0 = pops;
    f0 = fd_cnt;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("lat_rd", 64'(mem_rd), 64'd1);
    chk("lat_busy", 64'(busy), 64'd1);
    chk("lat_v0", 64'(vif.tvalid), 64'd0);
    tick();
    chk("lat_v1", 64'(vif.tvalid), 64'd0);
    tick();
    chk("lat_v2", 64'(vif.tvalid), 64'd1);
    chk("first_tuser", 64'(vif.tuser), 64'd1);
    chk("first_tdata", 64'(vif.tdata),
        64'(pix(32'h1000)));
    wait_idle("basic", 100);
    chk("basic_beats", 64'(pops - p0), 64'd8);
    chk("basic_frames", 64'(fd_cnt - f0), 64'd1);
    chk("basic_busy", 64'(busy), 64'd0);

    // Backpressure.
    ready_pct = 30;
    set_cfg(32'h2000_0000, 16'h40, 8, 3);
    add_frame(32'h2000_0000, 16'h40, 8, 3);
    p0 = pops;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_idle("bp", 2000);
    chk("bp_beats", 64'(pops - p0), 64'd24);
    ready_pct = 100;

    // Zero dimension.
    set_cfg(32'h3000, 16'h10, 0, 5);
    i0 = issued;
    max_busy = 1'b0;
    max_v = 1'b0;
    enable = 1'b1;
    repeat (20) begin
      tick();
      max_busy |= busy;
      max_v |= vif.tvalid;
    end
    enable = 1'b0;
    chk("zero_busy", 64'(max_busy), 64'd0);
    chk("zero_tvalid", 64'(max_v), 64'd0);
    chk("zero_reads", 64'(issued - i0), 64'd0);

    // Enable falls during line 0.
    set_cfg(32'h4000, 16'h20, 4, 2);
    add_frame(32'h4000, 16'h20, 4, 2);
    p0 = pops;
    f0 = fd_cnt;
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    wait_idle("endrop", 200);
    chk("endrop_beats", 64'(pops - p0), 64'd8);
    chk("endrop_frames", 64'(fd_cnt - f0), 64'd1);

    // Continuous run, hw changed mid-frame.
    set_cfg(32'h5000, 16'h40, 4, 2);
    add_frame(32'h5000, 16'h40, 4, 2);
    add_frame(32'h5000, 16'h40, 2, 2);
    p0 = pops;
    f0 = fd_cnt;
    enable = 1'b1;
    tick();
    cfg_hwords = 12'd2;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      tick();
      seen = frame_done;
      n++;
    end
    chk("cont_first_done", 64'(seen), 64'd1);
    enable = 1'b0;
    wait_idle("cont", 200);
    chk("cont_beats", 64'(pops - p0), 64'd12);
    chk("cont_frames", 64'(fd_cnt - f0), 64'd2);

    // Reset mid-frame at beat 3.
    set_cfg(32'h1000, 16'h20, 4, 2);
    add_frame(32'h1000, 16'h20, 4, 2);
    p0 = pops;
    enable = 1'b1;
    n = 0;
    while (pops - p0 < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("rst_reached_beat3", 64'(pops - p0 >= 3), 64'd1);
    aresetn = 1'b0;
    mon_en = 1'b0;
    tick();
    chk_zero("midrst");
    flush_model();
    add_frame(32'h1000, 16'h20, 4, 2);
    aresetn = 1'b1;
    mon_en = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    tick();
    chk("rst_fresh_tuser", 64'(vif.tuser), 64'd1);
    wait_idle("rst", 100);
    chk("rst_beats", 64'(pops), 64'd8);

    // Address wrap modulo 2^32.
    set_cfg(32'hFFFF_FFF8, 16'h100, 4, 1);
    add_frame(32'hFFFF_FFF8, 16'h100, 4, 1);
    chk("model_wrap1", 64'(addr_q[1]), 64'hFFFF_FFFC);
    chk("model_wrap2", 64'(addr_q[2]), 64'h0);
    chk("model_wrap3", 64'(addr_q[3]), 64'h4);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_idle("wrap", 100);

    // Random frames under random backpressure.
    for (int k = 0; k < 6; k++) begin
      logic [31:0] b;
      logic [15:0] s;
      int hw;
      int vl;
      b  = $urandom & 32'hFFFF_FFFC;
      s  = 16'($urandom_range(1024)) & 16'hFFFC;
      hw = int'($urandom_range(6, 1));
      vl = int'($urandom_range(4, 1));
      ready_pct = int'($urandom_range(100, 20));
      set_cfg(b, s, hw, vl);
      add_frame(b, s, hw, vl);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      wait_idle("rand", 1000);
    end

    chk("model_drained", 64'(exp_q.size() + addr_q.size()),
        64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vid_stream_source.md
Name: vid_stream_source

Overview:
- AXI4-Stream video master: reads a framebuffer through a synchronous-read memory port and emits 32-bit pixel words.
- Marks each frame with tuser on its first beat and each line with tlast on its last beat.
- It is the transmitting end for the m_axis_vid_* input of the video formatter, and also serves as an in-fabric replacement for VDMA on bring-up and test boards.
- Honours tready backpressure through a small tagged output FIFO that absorbs the memory read latency.

Parameters:
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)
ADDR_W, 32, memory address width

Ports:
m_axis_vid_aclk  in  1  clock
aresetn  in  1  reset; synchronous, active-low
enable  in  1  run frames while high
cfg_base  in  ADDR_W  byte address of pixel (0,0)
cfg_stride  in  16  bytes between line starts
cfg_hwords  in  12  32-bit words per line
cfg_vlines  in  12  lines per frame
mem_rd  out  1  read strobe
mem_addr  out  ADDR_W  byte address of read
mem_rdata  in  32  read data, valid exactly 1 cycle after mem_rd
m_axis_vid_tdata  out  32  pixel word
m_axis_vid_tvalid  out  1  beat valid
m_axis_vid_tready  in  1  sink ready
m_axis_vid_tlast  out  1  last word of line
m_axis_vid_tuser  out  1  first word of frame
busy  out  1  frame in progress
frame_done  out  1  1-cycle pulse on final beat handshake

Behaviour:
- Reset: aresetn sampled low at a clock edge clears every output (mem_rd, mem_addr, tvalid, tdata, tlast, tuser, busy, frame_done all 0). FIFO is emptied, in-flight read is discarded, state goes to IDLE. A reset mid-frame abandons the frame without a tlast.
- States:
  - IDLE: if enable && cfg_hwords!=0 && cfg_vlines!=0, latch cfg_* into working registers, set x=0, y=0, go to FETCH. Otherwise stay in IDLE with no reads.
  - FETCH: issue reads; when the last word (x=hw-1, y=vl-1) has been issued, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight, i.e. the final beat has handshaken. Then go to FETCH with freshly latched config if enable and dims are nonzero, else go to IDLE.
- busy=1 in FETCH and DRAIN.
- Read issue: mem_rd=1 in FETCH when fifo_count + inflight < FIFO_DEPTH (inflight is 0 or 1).
  - mem_addr = line_addr + 4*x, modulo 2^ADDR_W.
  - line_addr starts at base and gets +stride at each line wrap, so no multiplier is used.
  - x increments per read; at x=hw-1, x wraps to 0 and y increments.
- Tags: each read carries tuser=(x==0&&y==0) and tlast=(x==hw-1). The tag is delayed one cycle alongside mem_rdata and written with it as a 34-bit FIFO entry.
- Output:
  - FIFO head drives tdata/tlast/tuser; tvalid = !empty.
  - Pop on tvalid&&tready.
  - Once asserted, tvalid and the head payload stay stable until handshake.
  - Same-cycle push and pop on a full FIFO cannot occur, because issue is gated by the count.
  - Simultaneous push and pop leaves the count unchanged.
- Latency: with enable sampled high in IDLE at edge N:
  - mem_rd high in cycle N+1.
  - Data written into the FIFO at edge N+2.
  - tvalid high in cycle N+2 onward, i.e. first beat registered 2 cycles after the read strobe.
  - With tready held at 1, steady state is 1 beat per cycle.
- enable is sampled only in IDLE and DRAIN exit. Deassertion mid-frame completes the current frame, then goes to IDLE.
- cfg_* changes mid-frame have no effect until the next frame latch.
- frame_done pulses in the cycle the tlast&&y==vl-1 beat handshakes, registered so it is high the cycle after. Back-to-back frames produce no idle beat gap beyond DRAIN (at most 2 cycles).

Test Plan:
- Basic frame: base=0x1000, stride=0x20, hw=4, vl=2, tready=1 -> mem_addr sequence 0x1000,1004,1008,100C,1020,1024,1028,102C. Exactly 8 beats, tuser only on beat 1, tlast on beats 4 and 8, one frame_done, then busy=0 with enable low.
- Backpressure: hw=8, vl=3, tready random 30% high -> all 24 words arrive in order with correct tags. tvalid never drops without a handshake; outstanding (fifo+inflight) never exceeds 4.
- Zero dimension: hw=0, vl=5, enable=1 -> no mem_rd, tvalid stays 0, busy stays 0.
- Enable drop and config change: enable falls during line 0 of a 4x2 frame -> frame completes (8 beats), then IDLE. Continuous run with hw changed 4->2 mid-frame -> current frame uses 4, next frame uses 2.
- Reset mid-frame: aresetn low at beat 3 -> next cycle all outputs 0. After release with enable=1, a fresh frame starts at base with tuser on its first beat.
- Address wrap: base=0xFFFFFFF8, hw=4 -> addresses F8, FC, 0x0, 0x4 (wrap modulo 2^32).
